// File: rtl/sauria_cfg_pkg.sv
// Shared configuration types for the SAURIA datapath lanes.
package sauria_cfg_pkg;

  typedef enum logic [1:0] {DRN_IDLE, DRN_RUN, DRN_FLUSH, DRN_DONE} drain_state_t;

  // Mask with the lowest n of w bits set (partial-word write enables).
  function automatic logic [31:0] low_mask(input int unsigned n);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 32; k++) begin
      if (k < int'(n)) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fifo_memory_ff.sv
// Flop-based first-word-fall-through FIFO with synchronous clear.
module fifo_memory_ff #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_pop,
  output logic [OUT_W-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [IN_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign o_full  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign o_empty = (cnt_q == '0);
  assign o_data  = OUT_W'(mem_q[rd_q]);

  // A pop frees its slot in the same cycle, so a full FIFO can still accept.
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (i_clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !i_clear) mem_q[wr_q] <= i_data;
  end

endmodule

// File: rtl/drain_psum_lane.sv
// Drain lane: packs column results into SRAM words, buffers them and writes them out.
module drain_psum_lane
  import sauria_cfg_pkg::*;
#(
  parameter int unsigned FIFO_POSITIONS = 8,
  parameter int unsigned O_W            = 32,
  parameter int unsigned SRAM_W         = 128,
  parameter int unsigned ADR_W          = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [ADR_W-1:0]         i_base_addr,
  input  logic [ADR_W:0]           i_nwords,
  input  logic [O_W-1:0]           i_data,
  input  logic                     i_valid,
  input  logic                     i_pipeline_en,
  input  logic                     i_finalpush,
  input  logic                     i_clearfifo,
  input  logic                     i_sram_ready,
  output logic                     o_stall,
  output logic                     o_sram_wren,
  output logic [ADR_W-1:0]         o_sram_addr,
  output logic [SRAM_W-1:0]        o_sram_wdata,
  output logic [SRAM_W/O_W-1:0]    o_sram_wmask,
  output logic                     o_fifo_full,
  output logic                     o_fifo_empty,
  output logic                     o_done
);
  localparam int unsigned WPW    = SRAM_W / O_W;
  localparam int unsigned IDX_W  = $clog2(WPW);
  localparam int unsigned FIFO_W = SRAM_W + WPW;

  drain_state_t            state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [WPW-2:0][O_W-1:0] slots_q, slots_d;
  logic [ADR_W-1:0]        base_q, base_d, offset_q, offset_d, addr_q, addr_d;
  logic [ADR_W:0]          nwords_q, nwords_d, wcount_q, wcount_d;
  logic                    wren_q, wren_d;
  logic [SRAM_W-1:0]       wdata_q, wdata_d, push_data;
  logic [WPW-1:0]          wmask_q, wmask_d, push_mask;
  logic                    fifo_full, fifo_empty, fifo_clear, push, pop, cap, active;
  logic [FIFO_W-1:0]       head;

  assign active     = (state_q == DRN_RUN) || (state_q == DRN_FLUSH);
  assign cap        = i_valid & i_pipeline_en & ~fifo_full & (state_q == DRN_RUN) & ~i_clearfifo;
  assign pop        = active & ~fifo_empty & i_sram_ready & (wcount_q < nwords_q) & ~i_clearfifo;
  // Surplus words left over when a run completes are discarded.
  assign fifo_clear = i_clearfifo | (state_q == DRN_DONE);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    slots_d   = slots_q;
    base_d    = base_q;
    nwords_d  = nwords_q;
    offset_d  = offset_q;
    wcount_d  = wcount_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    wren_d    = 1'b0;
    push      = 1'b0;
    push_data = '0;
    push_mask = '0;

    if (cap) begin
      if (idx_q == IDX_W'(WPW - 1)) begin
        push      = 1'b1;
        push_data = {i_data, slots_q};
        push_mask = '1;
        idx_d     = '0;
      end else begin
        slots_d[idx_q] = i_data;
        idx_d          = idx_q + 1'b1;
      end
    end else if ((state_q == DRN_FLUSH) && (idx_q != '0) && (!fifo_full || pop)) begin
      // Partial word: unfilled slots stay zero and are masked off.
      push      = 1'b1;
      push_mask = WPW'(low_mask(32'(idx_q)));
      for (int k = 0; k < int'(WPW) - 1; k++) begin
        if (k < int'(idx_q)) push_data[k*O_W +: O_W] = slots_q[k];
      end
      idx_d = '0;
    end

    if (pop) begin
      wren_d   = 1'b1;
      addr_d   = base_q + offset_q;
      wdata_d  = head[SRAM_W-1:0];
      wmask_d  = head[FIFO_W-1 -: WPW];
      offset_d = offset_q + 1'b1;
      wcount_d = wcount_q + 1'b1;
    end

    case (state_q)
      DRN_IDLE: begin
        if (i_start) begin
          base_d   = i_base_addr;
          nwords_d = i_nwords;
          offset_d = '0;
          wcount_d = '0;
          state_d  = (i_nwords == '0) ? DRN_DONE : DRN_RUN;
        end
      end
      DRN_RUN: begin
        if (wcount_q == nwords_q) state_d = DRN_DONE;
        else if (i_finalpush)     state_d = DRN_FLUSH;
      end
      DRN_FLUSH: begin
        if ((wcount_q == nwords_q) || (fifo_empty && (idx_q == '0))) state_d = DRN_DONE;
      end
      DRN_DONE: begin
        idx_d   = '0;
        state_d = DRN_IDLE;
      end
      default: state_d = DRN_IDLE;
    endcase

    if (i_clearfifo) begin
      state_d = DRN_IDLE;
      idx_d   = '0;
      slots_d = '0;
      wren_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= DRN_IDLE;
      idx_q    <= '0;
      slots_q  <= '0;
      base_q   <= '0;
      nwords_q <= '0;
      offset_q <= '0;
      wcount_q <= '0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      slots_q  <= slots_d;
      base_q   <= base_d;
      nwords_q <= nwords_d;
      offset_q <= offset_d;
      wcount_q <= wcount_d;
      wren_q   <= wren_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

  fifo_memory_ff #(
    .DEPTH (FIFO_POSITIONS),
    .IN_W  (FIFO_W),
    .OUT_W (FIFO_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (fifo_clear),
    .i_push  (push),
    .i_data  ({push_mask, push_data}),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_stall      = fifo_full;
  assign o_fifo_full  = fifo_full;
  assign o_fifo_empty = fifo_empty;
  assign o_sram_wren  = wren_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = wdata_q;
  assign o_sram_wmask = wmask_q;
  assign o_done       = (state_q == DRN_DONE);

endmodule
